// File: rtl/seq_pkg.sv
// Shared opcode and state encodings for the register-file/ALU micro-sequencer.
// Opcode values 0..5 are identical to the ALU operation encoding.
package seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLT = 3'd5,
    OP_LDI = 3'd6,
    OP_RD  = 3'd7
  } seq_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    EXEC = 3'd2,
    WB   = 3'd3,
    RSP  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/seq_alu.sv
// Combinational DW-bit ALU; add/sub wrap with no carry out, SLT is a signed compare.
module seq_alu
  import seq_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic [2:0]    op_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (seq_op_e'(op_i))
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_SLT:  y_o = {{(DW - 1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/seq_reg_file.sv
// 2**AW x DW register file: two combinational read ports, one synchronous write port.
// All entries clear on reset; there is no hardwired-zero entry.
module seq_reg_file
  import seq_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [AW-1:0] raddr_a_i,
  output logic [DW-1:0] rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_b_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i
);

  localparam int Depth = 2 ** AW;

  logic [DW-1:0] r_mem [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = r_mem[raddr_a_i];
  assign rdata_b_o = r_mem[raddr_b_i];

endmodule

// File: rtl/rf_alu_sequencer.sv
// Runs one register-to-register instruction at a time: read -> ALU -> write back -> respond.
// LDI skips read/exec; RD skips exec/write and returns the rs1 value.
module rf_alu_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 3,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [2:0]      instr_op_i,
  input  logic [AW-1:0]   instr_rd_i,
  input  logic [AW-1:0]   instr_rs1_i,
  input  logic [AW-1:0]   instr_rs2_i,
  input  logic [DW-1:0]   instr_imm_i,
  output logic [AW-1:0]   rf_rs1_addr_o,
  output logic [AW-1:0]   rf_rs2_addr_o,
  input  logic [DW-1:0]   rf_rs1_data_i,
  input  logic [DW-1:0]   rf_rs2_data_i,
  output logic            rf_rd_wren_o,
  output logic [AW-1:0]   rf_rd_addr_o,
  output logic [DW-1:0]   rf_rd_data_o,
  output logic [2:0]      alu_op_o,
  output logic [DW-1:0]   alu_a_o,
  output logic [DW-1:0]   alu_b_o,
  input  logic [DW-1:0]   alu_y_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_data_o,
  output logic [AW-1:0]   rsp_rd_o,
  output logic [CNTW-1:0] retired_o
);

  seq_state_e    r_state;
  seq_state_e    w_state_d;
  logic          r_ready;
  logic          w_accept;
  logic [2:0]    r_op;
  logic [AW-1:0] r_rd, r_rs1, r_rs2;
  logic [2:0]    r_alu_op;
  logic [DW-1:0] r_opa, r_opb;
  logic [AW-1:0] r_wb_addr;
  logic [DW-1:0] r_wb_data;
  logic [DW-1:0] r_rsp_data;
  logic [AW-1:0] r_rsp_rd;
  logic [CNTW-1:0] r_retired;

  assign w_accept = instr_valid_i & r_ready;

  always_comb begin
    w_state_d = IDLE;
    case (r_state)
      IDLE:    w_state_d = w_accept ? ((instr_op_i == OP_LDI) ? WB : READ) : IDLE;
      READ:    w_state_d = (r_op == OP_RD) ? RSP : EXEC;
      EXEC:    w_state_d = WB;
      WB:      w_state_d = RSP;
      RSP:     w_state_d = rsp_ready_i ? IDLE : RSP;
      default: w_state_d = IDLE;
    endcase
  end

  // ALU operands and write-back port are loaded only on entry to EXEC/WB so they
  // hold their last values at all other times.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_ready    <= 1'b0;
      r_op       <= '0;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_alu_op   <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_rsp_data <= '0;
      r_rsp_rd   <= '0;
      r_retired  <= '0;
    end else begin
      r_state <= w_state_d;
      r_ready <= (w_state_d == IDLE);
      if (w_accept) begin
        r_op  <= instr_op_i;
        r_rd  <= instr_rd_i;
        r_rs1 <= instr_rs1_i;
        r_rs2 <= instr_rs2_i;
        if (instr_op_i == OP_LDI) begin
          r_wb_addr <= instr_rd_i;
          r_wb_data <= instr_imm_i;
        end
      end
      if (r_state == READ) begin
        if (r_op == OP_RD) begin
          r_rsp_data <= rf_rs1_data_i;
          r_rsp_rd   <= r_rd;
        end else begin
          r_opa    <= rf_rs1_data_i;
          r_opb    <= rf_rs2_data_i;
          r_alu_op <= r_op;
        end
      end
      if (r_state == EXEC) begin
        r_wb_addr <= r_rd;
        r_wb_data <= alu_y_i;
      end
      if (r_state == WB) begin
        r_rsp_data <= r_wb_data;
        r_rsp_rd   <= r_wb_addr;
      end
      if ((r_state == RSP) && rsp_ready_i) begin
        r_retired <= r_retired + CNTW'(1);
      end
    end
  end

  assign instr_ready_o = r_ready;
  assign rf_rs1_addr_o = r_rs1;
  assign rf_rs2_addr_o = r_rs2;
  // Gated so a reset landing on WB never reaches the register file.
  assign rf_rd_wren_o  = (r_state == WB) & ~rst_i;
  assign rf_rd_addr_o  = r_wb_addr;
  assign rf_rd_data_o  = r_wb_data;
  assign alu_op_o      = r_alu_op;
  assign alu_a_o       = r_opa;
  assign alu_b_o       = r_opb;
  assign rsp_valid_o   = (r_state == RSP);
  assign rsp_data_o    = r_rsp_data;
  assign rsp_rd_o      = r_rsp_rd;
  assign retired_o     = r_retired;

endmodule
